// File: rtl/lc4_iter_divider.sv
// Iterative restoring divider for the LC4 execute stage (DIV/MOD).
// Resolves STEPS quotient bits per clock through a chain of cla16 subtractors.

// 16-bit carry-lookahead adder: 4-bit groups with a lookahead carry across groups.
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  // Group generate/propagate, group carries, then bit carries inside each group
  always_comb begin
    g = a & b;
    p = a ^ b;
    for (int unsigned k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = cin;
    for (int unsigned k = 0; k < 4; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    c = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i % 4 == 0) c[i] = gc[i/4];
      else            c[i] = g[i-1] | (p[i-1] & c[i-1]);
    end
    sum  = p ^ c;
    cout = gc[4];
  end
endmodule

module lc4_iter_divider #(
  parameter int STEPS = 1,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_dividend,
  input  logic [15:0]      in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_quotient,
  output logic [15:0]      out_remainder,
  output logic [TAG_W-1:0] out_tag
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [4:0]       cnt;
  logic [15:0]      q;
  logic [15:0]      rem;
  logic [15:0]      dvs;
  logic [TAG_W-1:0] tag;
  logic [15:0]      q_next;
  logic [15:0]      rem_next;

  // Restoring step chain: each stage consumes the previous stage's remainder/quotient.
  // Carry-out of rem - divisor is exactly (shifted[15:0] >= divisor).
  for (genvar s = 0; s < STEPS; s++) begin : g_step
    logic [15:0] rem_in;
    logic [15:0] q_in;
    logic [16:0] shifted;
    logic [15:0] diff;
    logic        cout;
    logic        ge;
    logic [15:0] rem_out;
    logic [15:0] q_out;

    if (s == 0) begin : g_first
      assign rem_in = rem;
      assign q_in   = q;
    end else begin : g_next
      assign rem_in = g_step[s-1].rem_out;
      assign q_in   = g_step[s-1].q_out;
    end

    assign shifted = {rem_in, q_in[15]};
    cla16 u_cla (
      .a    (shifted[15:0]),
      .b    (~dvs),
      .cin  (1'b1),
      .sum  (diff),
      .cout (cout)
    );
    assign ge      = shifted[16] | cout;
    assign rem_out = ge ? diff : shifted[15:0];
    assign q_out   = {q_in[14:0], ge};
  end

  assign q_next   = g_step[STEPS-1].q_out;
  assign rem_next = g_step[STEPS-1].rem_out;

  // Control FSM with registered handshakes; output registers load only on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      q             <= '0;
      rem           <= '0;
      dvs           <= '0;
      tag           <= '0;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_tag       <= '0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            q        <= in_dividend;
            dvs      <= in_divisor;
            tag      <= in_tag;
            rem      <= '0;
            cnt      <= 5'(16 / STEPS);
            state    <= BUSY;
            in_ready <= 1'b0;
          end
        end
        BUSY: begin
          q   <= q_next;
          rem <= rem_next;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            state     <= DONE;
            out_valid <= 1'b1;
            // Divide by zero yields 0/0 (LC4 semantics) after the full iteration count
            out_quotient  <= (dvs == '0) ? '0 : q_next;
            out_remainder <= (dvs == '0) ? '0 : rem_next;
            out_tag       <= tag;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lc4_iter_divider.sv
// Directed bench for lc4_iter_divider: STEPS=1 and STEPS=4 instances share stimulus.
module tb_lc4_iter_divider;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_dividend;
  logic [15:0] in_divisor;
  logic [3:0]  in_tag;
  logic        out_ready;

  logic        in_ready1, out_valid1, in_ready4, out_valid4;
  logic [15:0] quot1, rem1, quot4, rem4;
  logic [3:0]  tag1, tag4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lc4_iter_divider #(.STEPS(1), .TAG_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_quotient(quot1), .out_remainder(rem1), .out_tag(tag1)
  );

  lc4_iter_divider #(.STEPS(4), .TAG_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_quotient(quot4), .out_remainder(rem4), .out_tag(tag4)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Accept one operation (called #1 after a rising edge), check latency and
  // results on both instances, hold out_ready low for `hold` cycles, then drain.
  task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] t, input logic [15:0] eq, input logic [15:0] er,
                        input int hold);
    int n;
    int lat1;
    int lat4;
    check({nm, "_rdy1_pre"}, 32'(in_ready1), 1);
    check({nm, "_rdy4_pre"}, 32'(in_ready4), 1);
    in_valid = 1'b1; in_dividend = a; in_divisor = b; in_tag = t;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({nm, "_rdy1_busy"}, 32'(in_ready1), 0);
    n = 0; lat1 = -1; lat4 = -1;
    while ((lat1 < 0 || lat4 < 0) && n < 40) begin
      @(posedge clk); #1; n++;
      if (out_valid1 && lat1 < 0) lat1 = n;
      if (out_valid4 && lat4 < 0) lat4 = n;
    end
    check({nm, "_lat1"}, 32'(lat1), 16);
    check({nm, "_lat4"}, 32'(lat4), 4);
    check({nm, "_q1"}, 32'(quot1), 32'(eq));
    check({nm, "_r1"}, 32'(rem1), 32'(er));
    check({nm, "_t1"}, 32'(tag1), 32'(t));
    check({nm, "_q4"}, 32'(quot4), 32'(eq));
    check({nm, "_r4"}, 32'(rem4), 32'(er));
    check({nm, "_t4"}, 32'(tag4), 32'(t));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_dividend = 16'h0055; in_divisor = 16'h0002; in_tag = 4'hF;
      @(posedge clk); #1;
      check({nm, "_hold_v1"}, 32'(out_valid1), 1);
      check({nm, "_hold_q1"}, 32'(quot1), 32'(eq));
      check({nm, "_hold_r1"}, 32'(rem1), 32'(er));
      check({nm, "_hold_rdy1"}, 32'(in_ready1), 0);
      check({nm, "_hold_v4"}, 32'(out_valid4), 1);
      check({nm, "_hold_t4"}, 32'(tag4), 32'(t));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, "_drain_v1"}, 32'(out_valid1), 0);
    check({nm, "_drain_rdy1"}, 32'(in_ready1), 1);
    check({nm, "_drain_v4"}, 32'(out_valid4), 0);
    check({nm, "_drain_rdy4"}, 32'(in_ready4), 1);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_dividend = '0; in_divisor = '0; in_tag = '0;
    #12;
    check("rst_rdy1", 32'(in_ready1), 1);
    check("rst_v1", 32'(out_valid1), 0);
    check("rst_q1", 32'(quot1), 0);
    check("rst_r1", 32'(rem1), 0);
    check("rst_t1", 32'(tag1), 0);
    check("rst_v4", 32'(out_valid4), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("d100_7",   16'd100,  16'd7,    4'h3, 16'h000E, 16'h0002, 0);
    run_op("ffff_1",   16'hFFFF, 16'h0001, 4'h5, 16'hFFFF, 16'h0000, 0);
    run_op("1234_ffff",16'h1234, 16'hFFFF, 4'h6, 16'h0000, 16'h1234, 0);
    run_op("div0",     16'hABCD, 16'h0000, 4'h7, 16'h0000, 16'h0000, 0);
    run_op("bp",       16'd1000, 16'd33,   4'h9, 16'd30,   16'd10,   5);

    // Flush at busy cycle 8 (the STEPS=4 result is already waiting and is dropped)
    in_valid = 1'b1; in_dividend = 16'd500; in_divisor = 16'd7; in_tag = 4'h2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_rdy1", 32'(in_ready1), 1);
    check("flush_v1", 32'(out_valid1), 0);
    check("flush_rdy4", 32'(in_ready4), 1);
    check("flush_v4", 32'(out_valid4), 0);
    begin
      int seen;
      seen = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (out_valid1 || out_valid4) seen++;
      end
      check("flush_no_valid", 32'(seen), 0);
    end
    run_op("d9_3",     16'd9,    16'd3,    4'h1, 16'd3,    16'd0,    0);
    run_op("d8000_3",  16'h8000, 16'h0003, 4'hA, 16'h2AAA, 16'h0002, 0);

    // Asynchronous reset two cycles into an operation
    in_valid = 1'b1; in_dividend = 16'h8000; in_divisor = 16'h0003; in_tag = 4'hC;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_v4", 32'(out_valid4), 0);
    check("arst_q4", 32'(quot4), 0);
    check("arst_r4", 32'(rem4), 0);
    check("arst_t4", 32'(tag4), 0);
    check("arst_rdy4", 32'(in_ready4), 1);
    check("arst_q1", 32'(quot1), 0);
    #3;
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (out_valid1 || out_valid4) seen++;
      end
      check("arst_no_valid", 32'(seen), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lc4_iter_divider.md
Name: lc4_iter_divider

Overview:
- Iterative unsigned 16-bit divider for the LC4 execute stage; implements DIV and MOD semantics.
- Sits directly upstream of cla16 and feeds it: each iteration drives the remainder/divisor subtraction into cla16 instance(s), then consumes the 16-bit sum to update the partial remainder.
- Valid/ready handshakes on both sides so the superscalar pipeline can stall or squash it.

Parameters:
- STEPS, 1, quotient bits resolved per clock; legal values 1, 2, 4; one cla16 instance per step, chained combinationally.
- TAG_W, 4, width of the opaque tag (destination register and slot) carried with the operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous squash of any in-flight or completed operation.
- in_valid  input  1  operand set is valid.
- in_ready  output  1  block accepts operands this cycle.
- in_dividend  input  16  unsigned dividend.
- in_divisor  input  16  unsigned divisor.
- in_tag  input  TAG_W  tag returned with the result.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- out_quotient  output  16  unsigned quotient.
- out_remainder  output  16  unsigned remainder.
- out_tag  output  TAG_W  tag of the completed operation.

Behaviour:
- Clock and reset: one clock (clk); asynchronous active-low reset (rst_n).
- Reset values:
  - State is IDLE; iteration counter is 0.
  - in_ready=1, out_valid=0.
  - out_quotient=0, out_remainder=0, out_tag=0.
- States:
  - IDLE: in_ready=1.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE to BUSY: on in_valid&&in_ready&&!flush.
  - Latch the dividend into the quotient shift register, the divisor, and the tag.
  - Clear the partial remainder.
  - Set the counter to 16/STEPS.
- BUSY, per step (restoring algorithm):
  - shifted = {rem[15:0], q[15]} (17 bits).
  - diff = cla16(a=shifted[15:0], b=~divisor, cin=1).
  - ge = shifted[16] | (shifted[15:0] >= divisor).
  - rem = ge ? diff : shifted[15:0].
  - q = {q[14:0], ge}.
  - Steps chain combinationally within one cycle when STEPS>1.
  - The counter decrements once per cycle; when it reaches 0, move to DONE.
- Latency: acceptance edge plus 16/STEPS cycles. out_valid rises exactly 16/STEPS cycles after the accepting edge (16, 8 or 4).
- Divisor 0: out_quotient=0 and out_remainder=0, per LC4 DIV/MOD semantics. The block runs the same number of cycles, with no early exit.
- DONE:
  - Outputs held stable while out_valid&&!out_ready.
  - On out_ready, move to IDLE; out_valid drops the next cycle.
  - in_ready=1 again one cycle after the result is consumed. There is no overlap of an accept with a result drain.
- flush:
  - Highest priority over every other event.
  - From any state, the next state is IDLE and out_valid=0.
  - The counter and partial state are discarded.
  - flush together with in_valid does not accept the operand.
  - flush together with out_ready in DONE: the result is dropped; the consumer must ignore it.
- rst_n low mid-operation: returns to reset values immediately, without waiting for a clock edge; no result is produced.
- Output registers update only on entry to DONE. out_quotient, out_remainder and out_tag otherwise retain their last value.
- in_* values are ignored while in_ready=0.

Test Plan:
- STEPS=1, accept 100/7 with tag 0x3 -> out_valid exactly 16 cycles later; quotient 14 (0x000E), remainder 2, tag 0x3.
- STEPS=1, 0xFFFF/0x0001, then 0x1234/0xFFFF -> first result 0xFFFF r 0x0000; second result 0x0000 r 0x1234.
- Divisor zero: 0xABCD/0 -> quotient 0x0000, remainder 0x0000, after the full 16 cycles.
- Backpressure: result ready, out_ready held low 5 cycles -> out_valid stays 1 with stable data; in_ready stays 0; in_valid pulses are ignored; after out_ready, in_ready returns 1 one cycle later.
- Flush at busy cycle 8 -> out_valid never asserts and in_ready=1 the next cycle. Then 9/3 -> quotient 3, remainder 0.
- STEPS=4: 0x8000/0x0003 -> out_valid 4 cycles after accept; quotient 0x2AAA, remainder 0x0002. A second run with rst_n pulsed low at cycle 2 -> outputs return to reset values asynchronously and no out_valid appears.
